disaggregator: RTL and testbench

DISAGGREGATOR -- requirements
Module: disaggregator

---
 rtl/aggregator_pkg.sv | 17 +
 rtl/disaggregator_if.sv | 36 +++
 rtl/disaggregator_slice_mux.sv | 28 ++
 rtl/disaggregator.sv | 67 ++++++
 tb/tb_disaggregator.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/aggregator_pkg.sv
// Shared constants and state type for the aggregator/disaggregator pair.
package aggregator_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_FETCH_WIDTH = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } agg_state_t;

  // Slice index width; a single-slice word still needs one bit.
  function automatic int idx_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

endpackage

// File: rtl/disaggregator_if.sv
// FIFO-side handshake bundle for the disaggregator.
// DISAGGREGATOR_LAST_EN adds receiver_last, marking the final slice of each wide word.
interface disaggregator_if
  import aggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
`ifdef DISAGGREGATOR_LAST_EN
  logic                              receiver_last;
`endif

  modport master (
    output sender_deq, receiver_data, receiver_enq,
`ifdef DISAGGREGATOR_LAST_EN
    receiver_last,
`endif
    input  sender_data, sender_empty_n, receiver_full_n
  );

  modport slave (
    input  sender_deq, receiver_data, receiver_enq,
`ifdef DISAGGREGATOR_LAST_EN
    receiver_last,
`endif
    output sender_data, sender_empty_n, receiver_full_n
  );

endinterface

// File: rtl/disaggregator_slice_mux.sv
// Selects one DATA_WIDTH slice of the held wide word; slice 0 is the low bits.
module disaggregator_slice_mux
  import aggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
  parameter int IDX_W       = idx_width(FETCH_WIDTH)
)
(
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] hold,
  input  logic [IDX_W-1:0]                  idx,
  output logic [DATA_WIDTH-1:0]             data
);

  logic [DATA_WIDTH-1:0] slices [FETCH_WIDTH];

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slice
    assign slices[gi] = hold[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (idx == IDX_W'(i)) data = slices[i];
    end
  end

endmodule

// File: rtl/disaggregator.sv
// Unpacks wide FIFO words into FETCH_WIDTH narrow words, slice 0 first, one per cycle.
// Optional receiver_last output enabled by DISAGGREGATOR_LAST_EN.
module disaggregator
  import aggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  disaggregator_if.master  bus
);

  localparam int               IDX_W    = idx_width(FETCH_WIDTH);
  localparam int               WIDE_W   = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

  agg_state_t        state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [WIDE_W-1:0] hold_reg;

  logic last_slice;
  logic enq;
  logic deq;

  assign last_slice = (idx_reg == LAST_IDX);
  assign enq = !rst && (state_reg == ST_DRAIN) && bus.receiver_full_n;
  // Reload on the final slice's transfer so back-to-back words have no bubble.
  assign deq = !rst && bus.sender_empty_n &&
               ((state_reg == ST_EMPTY) || (enq && last_slice));

  assign bus.sender_deq   = deq;
  assign bus.receiver_enq = enq;
`ifdef DISAGGREGATOR_LAST_EN
  assign bus.receiver_last = enq && last_slice;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      idx_reg   <= '0;
      hold_reg  <= '0;
    end else if (deq) begin
      state_reg <= ST_DRAIN;
      idx_reg   <= '0;
      hold_reg  <= bus.sender_data;
    end else if (enq) begin
      if (last_slice) begin
        state_reg <= ST_EMPTY;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  disaggregator_slice_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .IDX_W       (IDX_W)
  ) u_slice_mux (
    .hold (hold_reg),
    .idx  (idx_reg),
    .data (bus.receiver_data)
  );

endmodule

// File: tb/tb_disaggregator.sv
// Directed cycle-table bench for disaggregator (FETCH_WIDTH=2) plus a FETCH_WIDTH=1 sequence.
module tb_disaggregator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) bus2 ();
  disaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(1)) bus1 ();

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic        rst;
    logic [15:0] data;
    logic        empty_n;
    logic        full_n;
    logic        exp_deq;
    logic        exp_enq;
    logic        care;
    logic [7:0]  exp_data;
    logic        exp_last;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic [15:0] d, input logic en,
                              input logic fn, input logic xdeq, input logic xenq,
                              input logic care, input logic [7:0] xd, input logic xlast);
    vec_t v;
    v.rst = r; v.data = d; v.empty_n = en; v.full_n = fn;
    v.exp_deq = xdeq; v.exp_enq = xenq; v.care = care; v.exp_data = xd; v.exp_last = xlast;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    //            rst data      en fn deq enq care dat   last
    vecs[0]  = mk(1, 16'h0100, 1, 1, 0, 0, 0, 8'h00, 0); // reset gates outputs
    // back-to-back words, no backpressure
    vecs[1]  = mk(0, 16'h0100, 1, 1, 1, 0, 1, 8'h00, 0); // hold cleared by reset
    vecs[2]  = mk(0, 16'h0302, 1, 1, 0, 1, 1, 8'h00, 0);
    vecs[3]  = mk(0, 16'h0302, 1, 1, 1, 1, 1, 8'h01, 1);
    vecs[4]  = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h02, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h03, 1);
    vecs[6]  = mk(0, 16'h0000, 0, 1, 0, 0, 0, 8'h00, 0);
    // backpressure while 01 presented
    vecs[7]  = mk(0, 16'h0100, 1, 1, 1, 0, 0, 8'h00, 0);
    vecs[8]  = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h00, 0);
    vecs[9]  = mk(0, 16'h0302, 1, 0, 0, 0, 1, 8'h01, 0);
    vecs[10] = mk(0, 16'h0302, 1, 0, 0, 0, 1, 8'h01, 0);
    vecs[11] = mk(0, 16'h0302, 1, 0, 0, 0, 1, 8'h01, 0);
    vecs[12] = mk(0, 16'h0302, 1, 1, 1, 1, 1, 8'h01, 1);
    vecs[13] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h02, 0);
    vecs[14] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h03, 1);
    // sender runs dry, next word four cycles after the first deq
    vecs[15] = mk(0, 16'h0100, 1, 1, 1, 0, 0, 8'h00, 0);
    vecs[16] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h00, 0);
    vecs[17] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h01, 1);
    vecs[18] = mk(0, 16'h0000, 0, 1, 0, 0, 0, 8'h00, 0);
    vecs[19] = mk(0, 16'h0504, 1, 1, 1, 0, 0, 8'h00, 0);
    vecs[20] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h04, 0);
    vecs[21] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h05, 1);
    // reset mid-word discards the remaining slice
    vecs[22] = mk(0, 16'h0100, 1, 1, 1, 0, 0, 8'h00, 0);
    vecs[23] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h00, 0);
    vecs[24] = mk(1, 16'h0706, 1, 1, 0, 0, 0, 8'h00, 0);
    vecs[25] = mk(0, 16'h0706, 1, 1, 1, 0, 1, 8'h00, 0);
    vecs[26] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h06, 0);
    vecs[27] = mk(0, 16'h0000, 0, 1, 0, 1, 1, 8'h07, 1);
    vecs[28] = mk(0, 16'h0000, 0, 1, 0, 0, 0, 8'h00, 0);

    bus2.sender_data = '0; bus2.sender_empty_n = 1'b0; bus2.receiver_full_n = 1'b1;
    bus1.sender_data = '0; bus1.sender_empty_n = 1'b0; bus1.receiver_full_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst                  = vecs[i].rst;
      bus2.sender_data     = vecs[i].data;
      bus2.sender_empty_n  = vecs[i].empty_n;
      bus2.receiver_full_n = vecs[i].full_n;
      #3;
      $display("vec %0d: deq=%b enq=%b data=%h", i, bus2.sender_deq, bus2.receiver_enq,
               bus2.receiver_data);
      check($sformatf("v%0d deq", i), {15'd0, bus2.sender_deq}, {15'd0, vecs[i].exp_deq});
      check($sformatf("v%0d enq", i), {15'd0, bus2.receiver_enq}, {15'd0, vecs[i].exp_enq});
      if (vecs[i].care)
        check($sformatf("v%0d data", i), {8'd0, bus2.receiver_data}, {8'd0, vecs[i].exp_data});
`ifdef DISAGGREGATOR_LAST_EN
      check($sformatf("v%0d last", i), {15'd0, bus2.receiver_last}, {15'd0, vecs[i].exp_last});
`endif
    end

    // FETCH_WIDTH=1 pass-through: A0 then A1 streamed
    @(posedge clk); #1;
    bus1.sender_data = 8'hA0; bus1.sender_empty_n = 1'b1; #3;
    $display("w1 a: deq=%b enq=%b", bus1.sender_deq, bus1.receiver_enq);
    check("w1a deq", {15'd0, bus1.sender_deq}, 16'd1);
    check("w1a enq", {15'd0, bus1.receiver_enq}, 16'd0);

    @(posedge clk); #1;
    bus1.sender_data = 8'hA1; bus1.sender_empty_n = 1'b1; #3;
    $display("w1 b: deq=%b enq=%b data=%h", bus1.sender_deq, bus1.receiver_enq, bus1.receiver_data);
    check("w1b deq", {15'd0, bus1.sender_deq}, 16'd1);
    check("w1b enq", {15'd0, bus1.receiver_enq}, 16'd1);
    check("w1b data", {8'd0, bus1.receiver_data}, 16'h00A0);
`ifdef DISAGGREGATOR_LAST_EN
    check("w1b last", {15'd0, bus1.receiver_last}, 16'd1);
`endif

    @(posedge clk); #1;
    bus1.sender_data = 8'h00; bus1.sender_empty_n = 1'b0; #3;
    $display("w1 c: deq=%b enq=%b data=%h", bus1.sender_deq, bus1.receiver_enq, bus1.receiver_data);
    check("w1c deq", {15'd0, bus1.sender_deq}, 16'd0);
    check("w1c enq", {15'd0, bus1.receiver_enq}, 16'd1);
    check("w1c data", {8'd0, bus1.receiver_data}, 16'h00A1);

    @(posedge clk); #1; #3;
    $display("w1 d: deq=%b enq=%b", bus1.sender_deq, bus1.receiver_enq);
    check("w1d enq", {15'd0, bus1.receiver_enq}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
